// File: rtl/if_stage.sv
// Instruction fetch stage: req/ready memory port, one-entry skid buffer, redirect drain.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect pulses fetch_err and vectors to EXC_VECTOR.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] insout,
    output logic [31:0] nPCout,
    output logic        if_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH,
        BUF,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] out_addr;
    logic [31:0] out_addr_d;
    logic [31:0] buf_ins;
    logic [31:0] buf_ins_d;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_d;
    logic [31:0] ins_d;
    logic [31:0] npc_d;
    logic        valid_d;
    logic [31:0] target;
    logic        done;
    logic        go_redir;
    logic        go_drain;
    logic        go_buf;

    assign imem_req  = !reset && (state != BUF);
    assign imem_addr = (state == DRAIN) ? out_addr : pc;
    assign done      = imem_req && imem_ready;

`ifdef IF_ALIGN_CHECK_EN
    logic misal;

    assign misal  = redirect_pc[1:0] != 2'b00;
    assign target = misal ? EXC_VECTOR : (redirect_pc & 32'hFFFF_FFFC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= redirect && misal;
        end
    end
`else
    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_err = 1'b0;
`endif

    assign go_redir = redirect;
    assign go_drain = !redirect && (state == DRAIN);
    assign go_buf   = !redirect && (state == BUF);

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        out_addr_d = out_addr;
        buf_ins_d  = buf_ins;
        buf_pc_d   = buf_pc;
        ins_d      = insout;
        npc_d      = nPCout;
        valid_d    = if_valid;
        unique case (1'b1)
            go_redir: begin
                ins_d   = 32'h0;
                valid_d = 1'b0;
                pc_d    = target;
                state_d = FETCH;
                // A request still in flight must finish before a new one starts
                if ((state == FETCH) && !done) begin
                    state_d    = DRAIN;
                    out_addr_d = pc;
                end else if ((state == DRAIN) && !done) begin
                    state_d = DRAIN;
                end
            end
            go_drain: begin
                if (!hold) begin
                    ins_d   = 32'h0;
                    valid_d = 1'b0;
                end
                if (done) begin
                    state_d = FETCH;
                end
            end
            go_buf: begin
                if (!hold) begin
                    ins_d   = buf_ins;
                    npc_d   = buf_pc + 32'd4;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                if (done && hold) begin
                    buf_ins_d = imem_rdata;
                    buf_pc_d  = pc;
                    pc_d      = pc + 32'd4;
                    state_d   = BUF;
                end else if (done) begin
                    ins_d   = imem_rdata;
                    npc_d   = pc + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc + 32'd4;
                end else if (!hold) begin
                    ins_d   = 32'h0;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            out_addr <= 32'h0;
            buf_ins  <= 32'h0;
            buf_pc   <= 32'h0;
            insout   <= 32'h0;
            nPCout   <= 32'h0;
            if_valid <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            out_addr <= out_addr_d;
            buf_ins  <= buf_ins_d;
            buf_pc   <= buf_pc_d;
            insout   <= ins_d;
            nPCout   <= npc_d;
            if_valid <= valid_d;
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180: fetch address used after a misaligned redirect (REQ-026).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 hold  in  1  downstream stall; while high, insout/nPCout/if_valid SHALL not change.
REQ-006 redirect  in  1  branch/jump taken, sampled on posedge.
REQ-007 redirect_pc  in  32  redirect target address.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word address of the request.
REQ-010 imem_rdata  in  32  instruction data, valid only in a cycle with imem_ready=1.
REQ-011 imem_ready  in  1  request completion; any number of wait cycles, including zero.
REQ-012 insout  out  32  fetched instruction, or 32'h0 (NOP) for a bubble.
REQ-013 nPCout  out  32  address of insout + 4.
REQ-014 if_valid  out  1  insout holds a real fetched instruction.
REQ-015 fetch_err  out  1  one-cycle pulse on a misaligned redirect.

Function
REQ-016 Internal state: pc (32 bit), a one-entry skid buffer (instruction + address), FSM states FETCH, BUF, DRAIN.
REQ-017 A request completes when imem_req=1 and imem_ready=1 on the same posedge; imem_addr SHALL be held stable from request assertion until completion.
REQ-018 In FETCH and DRAIN: imem_req=1. In BUF: imem_req=0.
REQ-019 In FETCH, imem_addr=pc. In DRAIN, imem_addr SHALL equal the address of the outstanding request.
REQ-020 FETCH, completion, hold=0, redirect=0: insout<=imem_rdata, nPCout<=pc+4, if_valid<=1, pc<=pc+4. Zero-wait throughput is one instruction per cycle.
REQ-021 FETCH, no completion, hold=0, redirect=0: insout<=32'h0, if_valid<=0, nPCout unchanged (bubble).
REQ-022 FETCH, completion, hold=1, redirect=0: capture rdata and pc into the skid buffer; pc<=pc+4; go to BUF.
REQ-023 BUF, hold=0, redirect=0: output the buffer contents (if_valid<=1, nPCout<=buffered address+4); go to FETCH.
REQ-024 Redirect has priority over hold and over a completing response.
- Redirect at the same posedge as a completion, or in BUF: the response or buffer is discarded; pc<=target; go to FETCH.
- Redirect in FETCH with no completion: pc<=target; go to DRAIN.
- In every case: insout<=32'h0, if_valid<=0.
REQ-025 DRAIN: on completion, discard the data and go to FETCH. A further redirect while in DRAIN overwrites the target in pc. While in DRAIN, outputs SHALL be bubbles unless hold=1.
REQ-026 Target computation: target = redirect_pc with bits [1:0] forced to 2'b00, unless modified by REQ-030.
REQ-027 Address arithmetic is modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-028 On reset assertion, immediately and asynchronously:
- pc=RESET_PC, state=FETCH, skid buffer cleared.
- insout=32'h0, nPCout=32'h0, if_valid=0, fetch_err=0.
- Any outstanding response is dropped.
REQ-029 imem_req SHALL be 0 while reset is high and SHALL assert in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-030 When macro IF_ALIGN_CHECK_EN is defined, a redirect with redirect_pc[1:0]!=2'b00 SHALL pulse fetch_err for one cycle and SHALL use EXC_VECTOR as the target. Without IF_ALIGN_CHECK_EN, fetch_err is tied to 0 and REQ-026 applies.

Verification
REQ-031 Reset, zero-wait memory returning addr^32'hFFFF_FFFF: imem_addr sequence 3000, 3004, 3008; nPCout sequence 3004, 3008, 300C; if_valid=1 from the second cycle.
REQ-032 imem_ready delayed 2 cycles at 3004: two bubbles (insout=0, if_valid=0), then the 3004 instruction with nPCout=3008.
REQ-033 hold=1 for 3 cycles while a response completes: outputs frozen, imem_req=0 in BUF; on hold release the buffered instruction appears once, with no loss or duplication.
REQ-034 Redirect to 32'h0000_3100 while a request to 300C is pending 2 cycles: 300C data discarded; next request 3100; exactly one valid instruction at 3100 with nPCout=3104.
REQ-035 Redirect to 32'h0000_3102 with IF_ALIGN_CHECK_EN: fetch_err=1 for one cycle, next imem_addr=4180. Without the macro: fetch_err=0, next imem_addr=3100.
REQ-036 reset asserted mid-DRAIN: outputs cleared in the same cycle; the late imem_ready response is ignored; fetch restarts at 3000.
